// File: rtl/vend_pkg.sv
// Shared types for the water vending machine payout path: coin codes,
// payout FSM states and the queued job record.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DISPENSE = 3'd1,
    ST_FIRE     = 3'd2,
    ST_WAIT     = 3'd3,
    ST_FAULT    = 3'd4
  } payout_state_t;

  typedef struct packed {
    logic       bottle;
    logic [1:0] coins;
  } job_t;

endpackage

// File: rtl/vend_job_fifo.sv
// Synchronous job queue for the payout sequencer; head word is visible on
// dout whenever empty is low (first-word fall-through).
module vend_job_fifo
  import vend_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  job_t                     din,
  output job_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  job_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A push into a full queue still lands when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vend_payout.sv
// Payout sequencer: queues bottle/change jobs and drives motor then hopper,
// one coin per sensor handshake. Jam timeout built when VEND_PAYOUT_TIMEOUT_EN is defined.
module vend_payout
  import vend_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          out_req,
  input  logic [1:0]                    change_req,
  input  logic                          bottle_drop,
  input  logic                          coin_out,
  input  logic                          fault_clr,
  output logic                          motor_on,
  output logic                          hopper_fire,
  output logic                          busy,
  output logic                          fault,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic [2:0]                    dbg_state
);

  payout_state_t state;
  payout_state_t state_next;
  logic [1:0]    coins;
  logic [1:0]    coins_next;
  logic          req;
  logic          pop;
  logic          full;
  logic          empty;
  job_t          req_job;
  job_t          head;
  logic          tmo_hit;

  // Queue handshake: the producer offers a job every cycle req is high and
  // never waits; the sequencer takes the head (pop) only in IDLE with empty low.
  assign req     = out_req || (change_req != COIN_NONE);
  assign req_job = '{bottle: out_req, coins: change_req};

  vend_job_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req),
    .pop   (pop),
    .din   (req_job),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (pending)
  );

`ifdef VEND_PAYOUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // Hit one count early so FAULT is entered on the edge the count reaches TIMEOUT_CYC.
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign fault   = (state == ST_FAULT);

  always_ff @(posedge clk) begin
    if (rst || (state_next != state)) begin
      tmo_cnt <= '0;
    end else if ((state == ST_DISPENSE) || (state == ST_WAIT)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
  assign tmo_hit          = 1'b0;
  assign fault            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      coins    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      coins    <= coins_next;
      overflow <= req && full && !pop;
    end
  end

  always_comb begin
    state_next  = state;
    coins_next  = coins;
    pop         = 1'b0;
    motor_on    = 1'b0;
    hopper_fire = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          coins_next = head.coins;
          state_next = head.bottle ? ST_DISPENSE : ST_FIRE;
        end
      end
      ST_DISPENSE: begin
        motor_on = 1'b1;
        if (bottle_drop) begin
          state_next = (coins != 2'd0) ? ST_FIRE : ST_IDLE;
        end else if (tmo_hit) begin
          state_next = ST_FAULT;
          coins_next = '0;
        end
      end
      ST_FIRE: begin
        hopper_fire = 1'b1;
        state_next  = ST_WAIT;
      end
      ST_WAIT: begin
        if (coin_out) begin
          coins_next = coins - 2'd1;
          state_next = (coins_next != 2'd0) ? ST_FIRE : ST_IDLE;
        end else if (tmo_hit) begin
          state_next = ST_FAULT;
          coins_next = '0;
        end
      end
      ST_FAULT: begin
`ifdef VEND_PAYOUT_TIMEOUT_EN
        if (fault_clr) state_next = ST_IDLE;
`else
        state_next = ST_IDLE;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy      = (state != ST_IDLE) || !empty;
  assign dbg_state = state;

endmodule

// File: doc/vend_payout.md
# vend_payout

Payout back end for the water vending machine. It consumes the per-cycle `out`/`change` result of the coin-accepting FSM, queues each non-null result as a payout job, and sequences the physical actuators: the bottle motor, then the Rs 5 coin hopper, one coin at a time. Each actuator step closes on a sensor handshake, and jams are detected by a timeout.

## Interface
- `FIFO_DEPTH`, default 4: job queue depth; power of 2, ≥2.
- `TIMEOUT_CYC`, default 1000: cycles allowed per actuator step before a fault is raised.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `out_req`, in, 1: bottle owed in this cycle's result.
- `change_req`, in, 2: change owed, in Rs 5 units (0–3).
- `bottle_drop`, in, 1: bottle-chute sensor; high for ≥1 cycle when a bottle falls.
- `coin_out`, in, 1: hopper exit sensor; high for ≥1 cycle per coin ejected.
- `fault_clr`, in, 1: operator clear of a latched fault.
- `motor_on`, out, 1: bottle motor drive.
- `hopper_fire`, out, 1: single-cycle pulse that ejects one Rs 5 coin.
- `busy`, out, 1: high when the FSM is not in IDLE or the queue is non-empty.
- `fault`, out, 1: jam latched.
- `overflow`, out, 1: single-cycle pulse when a job is dropped.
- `pending`, out, log2(FIFO_DEPTH)+1: queue occupancy.

## Operation
- **Push.** A job is pushed in any cycle with `out_req`=1 or `change_req`≠0. Job = {bottle=`out_req`, coins=`change_req`}. Inputs are sampled every cycle, with no edge detection.
- **Full queue.** If the queue is full and no pop occurs in the same cycle, the job is dropped and `overflow` pulses. If a pop occurs in the same cycle, the push is accepted.
- **FSM states:** IDLE, DISPENSE, FIRE, WAIT, FAULT.
- **IDLE.** If the queue is non-empty, pop and load bottle/coins. Next state is DISPENSE if bottle=1, else FIRE (coins≠0 is guaranteed by the push rule).
- **DISPENSE.**
  - `motor_on`=1.
  - `bottle_drop`=1 → FIRE if coins>0, else IDLE.
  - `motor_on` drops in the cycle the state leaves DISPENSE.
- **FIRE.** `hopper_fire`=1 for exactly one cycle, then WAIT.
- **WAIT.** `coin_out`=1 → decrement coins. Next state is FIRE if the result is >0, else IDLE.
- **Sensor filtering.** Sensors are ignored in any state other than the one that consumes them. This covers stray, late or duplicate pulses.
- **Counter width.** The coin counter is 2 bits. It never underflows because the decrement happens only in WAIT with coins≥1.
- **Timeout counter.** Cleared on entry to DISPENSE and to WAIT. It increments while in either state; reaching `TIMEOUT_CYC` → FAULT.
- **FAULT.**
  - `fault`=1; `motor_on`=0; `hopper_fire`=0.
  - The in-flight job is discarded.
  - The queue keeps accepting pushes.
  - `fault_clr`=1 → IDLE next cycle, with `fault` low from that cycle.
- **Reset.** Applies in any state, including mid-dispense. Queue emptied; FSM to IDLE; all outputs 0; counters 0.

## Timing
- **Job start latency.** Request sampled at edge N is written at N. IDLE pops at N+1, so `motor_on` (or the first `hopper_fire`) is high in the cycle after edge N+1.
- **Back-to-back jobs.** The next job pops on the first IDLE cycle after return, so there is 1 idle cycle between jobs.
- **Dispense exit.** `bottle_drop` sampled high at edge M → state leaves DISPENSE at M, so `motor_on` is low after M.
- **Coin pacing.** `hopper_fire` pulses are separated by at least 2 cycles (FIRE, WAIT…).
- **Timeout.** The fault latches at the edge when the counter equals `TIMEOUT_CYC`, i.e. `TIMEOUT_CYC` cycles after step entry.
- **`pending`.** Updates on the edge of push/pop; a simultaneous push and pop leaves it unchanged.
- **`overflow`.** Asserted the cycle after the dropped request is sampled (registered).

## Configuration
- `VEND_PAYOUT_TIMEOUT_EN` defined: timeout counter, FAULT state and `fault_clr` are implemented as above.
- Undefined:
  - No timeout counter; DISPENSE and WAIT wait indefinitely.
  - FAULT is unreachable and removed.
  - `fault` is tied 0 and `fault_clr` is ignored.

## Structure
- **Package `vend_pkg`:**
  - Coin code constants: `COIN_NONE`=2'b00, `COIN_5`=2'b01, `COIN_10`=2'b10.
  - Payout state enum typedef.
  - Job struct typedef {bottle, coins[1:0]}.
- **Sub-module `vend_job_fifo`:**
  - Synchronous FIFO of job structs.
  - Ports: push, pop, full, empty, count.
  - Same `clk`/`rst`.
  - Instantiated once.

## Test plan
- **Single vend.** `out_req`=1 one cycle, `bottle_drop` 5 cycles later → `motor_on` high ≈6 cycles, no `hopper_fire`, `busy` returns to 0.
- **Vend with change.** `out_req`=1 and `change_req`=01 in the same cycle, then `bottle_drop`, then `coin_out` → exactly 1 `hopper_fire`, after `motor_on` falls.
- **Change only.** `change_req`=10 → 2 `hopper_fire` pulses, each acknowledged by `coin_out`; `motor_on` never asserts.
- **Overflow.** 5 consecutive requests with DEPTH=4 and the FSM stalled in DISPENSE → `pending` saturates at 4 and `overflow` pulses once; the stalled job plus 4 queued jobs complete after the sensors respond.
- **Jam.** With the macro defined and `TIMEOUT_CYC`=20, no `bottle_drop` → `fault`=1 at cycle 20 and `motor_on`=0. A new request gives `pending`=1. `fault_clr` → next job starts.
- **Reset mid-operation.** `rst` during DISPENSE with 2 jobs queued → next cycle `motor_on`=0, `pending`=0, `busy`=0. A later stray `bottle_drop` has no effect.
